// File: rtl/friscv_apb_arbiter.sv
// Round-robin arbiter that shares the interconnect's APB master port between NREQ requesters.
// One access is in flight at a time. Every access is followed by one idle cycle, and the
// wait for mst_ready is bounded by a timeout.
module friscv_apb_arbiter #(
  parameter int unsigned     NREQ    = 2,
  parameter int unsigned     ADDRW   = 16,
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     TIMEOUT = 255,
  parameter logic [XLEN-1:0] ERRDATA = 32'hDEADBEEF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   srst,
  input  logic [NREQ-1:0]        req_en,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [NREQ*ADDRW-1:0]  req_addr,
  input  logic [NREQ*XLEN-1:0]   req_wdata,
  input  logic [NREQ*XLEN/8-1:0] req_strb,
  output logic [XLEN-1:0]        req_rdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        req_err,
  output logic                   mst_en,
  output logic                   mst_wr,
  output logic [ADDRW-1:0]       mst_addr,
  output logic [XLEN-1:0]        mst_wdata,
  output logic [XLEN/8-1:0]      mst_strb,
  input  logic [XLEN-1:0]        mst_rdata,
  input  logic                   mst_ready
);

  localparam int unsigned STRBW = XLEN / 8;
  localparam int unsigned IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TMRW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMRW-1:0] TMR_LAST = (TIMEOUT > 0) ? TMRW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   ptr_q;
  logic [IDXW-1:0]   gnt_q;
  logic [TMRW-1:0]   timer_q;
  logic              mst_en_q;
  logic              mst_wr_q;
  logic [ADDRW-1:0]  mst_addr_q;
  logic [XLEN-1:0]   mst_wdata_q;
  logic [STRBW-1:0]  mst_strb_q;

  logic [IDXW-1:0]   gnt_d;
  logic [IDXW-1:0]   ptr_d;
  logic              expire_c;

  logic [ADDRW-1:0]  addr_a  [NREQ];
  logic [XLEN-1:0]   wdata_a [NREQ];
  logic [STRBW-1:0]  strb_a  [NREQ];

  // Split the flat requester buses into per-requester slices
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign addr_a[gi]  = req_addr[gi*ADDRW +: ADDRW];
    assign wdata_a[gi] = req_wdata[gi*XLEN +: XLEN];
    assign strb_a[gi]  = req_strb[gi*STRBW +: STRBW];
  end

  // First active request at or above ptr, wrapping at NREQ
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] en,
                                               input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] sel;
    logic            found;
    int unsigned     idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && en[idx[IDXW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDXW-1:0];
      end
    end
    return sel;
  endfunction

  assign gnt_d    = rr_pick(req_en, ptr_q);
  assign ptr_d    = (gnt_q == IDXW'(NREQ - 1)) ? '0 : gnt_q + IDXW'(1);
  assign expire_c = (TIMEOUT != 0) && (state_q == S_BUSY) && (timer_q == TMR_LAST) && !mst_ready;

  // Arbitration FSM, latched master-side payload and access timer
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      timer_q     <= '0;
      mst_en_q    <= 1'b0;
      mst_wr_q    <= 1'b0;
      mst_addr_q  <= '0;
      mst_wdata_q <= '0;
      mst_strb_q  <= '0;
    end else if (srst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      timer_q     <= '0;
      mst_en_q    <= 1'b0;
      mst_wr_q    <= 1'b0;
      mst_addr_q  <= '0;
      mst_wdata_q <= '0;
      mst_strb_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req_en) begin
            gnt_q       <= gnt_d;
            mst_en_q    <= 1'b1;
            mst_wr_q    <= req_wr[gnt_d];
            mst_addr_q  <= addr_a[gnt_d];
            mst_wdata_q <= wdata_a[gnt_d];
            mst_strb_q  <= strb_a[gnt_d];
            timer_q     <= '0;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mst_ready || expire_c) begin
            mst_en_q <= 1'b0;
            ptr_q    <= ptr_d;
            state_q  <= S_RELEASE;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + TMRW'(1);
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Completion / timeout response routed to the granted requester only
  always_comb begin
    req_ready = '0;
    req_err   = '0;
    req_rdata = '0;
    if ((state_q == S_BUSY) && !srst) begin
      if (mst_ready) begin
        req_ready[gnt_q] = 1'b1;
        req_rdata        = mst_rdata;
      end else if (expire_c) begin
        req_ready[gnt_q] = 1'b1;
        req_err[gnt_q]   = 1'b1;
        req_rdata        = ERRDATA;
      end
    end
  end

  assign mst_en    = mst_en_q;
  assign mst_wr    = mst_wr_q;
  assign mst_addr  = mst_addr_q;
  assign mst_wdata = mst_wdata_q;
  assign mst_strb  = mst_strb_q;

endmodule

// File: tb/tb_friscv_apb_arbiter.sv
// Bench for friscv_apb_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level round-robin model.
module tb_friscv_apb_arbiter;

  localparam int NREQ    = 3;
  localparam int ADDRW   = 16;
  localparam int XLEN    = 32;
  localparam int STRBW   = XLEN / 8;
  localparam int TIMEOUT = 16;
  localparam logic [XLEN-1:0] ERRDATA = 32'hDEADBEEF;

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic                   srst = 1'b0;
  logic [NREQ-1:0]        req_en;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*ADDRW-1:0]  req_addr;
  logic [NREQ*XLEN-1:0]   req_wdata;
  logic [NREQ*STRBW-1:0]  req_strb;
  logic [XLEN-1:0]        req_rdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_err;
  logic                   mst_en;
  logic                   mst_wr;
  logic [ADDRW-1:0]       mst_addr;
  logic [XLEN-1:0]        mst_wdata;
  logic [STRBW-1:0]       mst_strb;
  logic [XLEN-1:0]        mst_rdata;
  logic                   mst_ready;

  friscv_apb_arbiter #(
    .NREQ    (NREQ),
    .ADDRW   (ADDRW),
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT),
    .ERRDATA (ERRDATA)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .req_en    (req_en),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_rdata (req_rdata),
    .req_ready (req_ready),
    .req_err   (req_err),
    .mst_en    (mst_en),
    .mst_wr    (mst_wr),
    .mst_addr  (mst_addr),
    .mst_wdata (mst_wdata),
    .mst_strb  (mst_strb),
    .mst_rdata (mst_rdata),
    .mst_ready (mst_ready)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: pending requests with payloads, and the round-robin start point
  logic             pend    [NREQ];
  logic             p_wr    [NREQ];
  logic [ADDRW-1:0] p_addr  [NREQ];
  logic [XLEN-1:0]  p_wdata [NREQ];
  logic [STRBW-1:0] p_strb  [NREQ];
  int               ptr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic new_req(input int i, input logic wr, input logic [ADDRW-1:0] a,
                         input logic [XLEN-1:0] d, input logic [STRBW-1:0] s);
    pend[i]    = 1'b1;
    p_wr[i]    = wr;
    p_addr[i]  = a;
    p_wdata[i] = d;
    p_strb[i]  = s;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_en[i]                     = pend[i];
      req_wr[i]                     = p_wr[i];
      req_addr[i*ADDRW +: ADDRW]    = p_addr[i];
      req_wdata[i*XLEN +: XLEN]     = p_wdata[i];
      req_strb[i*STRBW +: STRBW]    = p_strb[i];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mst_en"},    64'(mst_en),    64'd0);
    chk({tag, "_mst_wr"},    64'(mst_wr),    64'd0);
    chk({tag, "_mst_addr"},  64'(mst_addr),  64'd0);
    chk({tag, "_mst_wdata"}, 64'(mst_wdata), 64'd0);
    chk({tag, "_mst_strb"},  64'(mst_strb),  64'd0);
    chk({tag, "_ready"},     64'(req_ready), 64'd0);
    chk({tag, "_err"},       64'(req_err),   64'd0);
    chk({tag, "_rdata"},     64'(req_rdata), 64'd0);
  endtask

  // One full transaction from an IDLE cycle; slave answers on BUSY cycle lat (never if lat>TIMEOUT)
  task automatic run_txn(input int lat, input logic [XLEN-1:0] rd);
    int   w;
    logic done;
    logic tmo;
    drive_reqs();
    #1;
    chk("idle_mst_en", 64'(mst_en), 64'd0);
    chk("idle_ready",  64'(req_ready), 64'd0);
    w = rr_winner(ptr);
    @(posedge aclk); #1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      mst_ready = (c == lat);
      mst_rdata = (c == lat) ? rd : $urandom;
      if (c == 1) begin
        // Granted requester's bus wiggles; the latched access must not follow it
        req_en[w]                  = 1'b0;
        req_wr[w]                  = ~p_wr[w];
        req_addr[w*ADDRW +: ADDRW] = ~p_addr[w];
        req_wdata[w*XLEN +: XLEN]  = ~p_wdata[w];
        req_strb[w*STRBW +: STRBW] = ~p_strb[w];
      end
      tmo  = (c == TIMEOUT) && (c != lat);
      done = (c == lat) || tmo;
      #1;
      chk("busy_mst_en",    64'(mst_en),    64'd1);
      chk("busy_mst_wr",    64'(mst_wr),    64'(p_wr[w]));
      chk("busy_mst_addr",  64'(mst_addr),  64'(p_addr[w]));
      chk("busy_mst_wdata", 64'(mst_wdata), 64'(p_wdata[w]));
      chk("busy_mst_strb",  64'(mst_strb),  64'(p_strb[w]));
      chk("busy_ready",     64'(req_ready), done ? (64'd1 << w) : 64'd0);
      chk("busy_err",       64'(req_err),   tmo  ? (64'd1 << w) : 64'd0);
      chk("busy_rdata",     64'(req_rdata), !done ? 64'd0 : (tmo ? 64'(ERRDATA) : 64'(rd)));
      if (done) break;
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    mst_ready = 1'b0;
    pend[w]   = 1'b0;
    drive_reqs();
    #1;
    chk("release_mst_en", 64'(mst_en),    64'd0);
    chk("release_ready",  64'(req_ready), 64'd0);
    ptr = (w + 1) % NREQ;
    @(posedge aclk); #1;
  endtask

  initial begin
    int any;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; p_strb[i] = '0;
    end
    drive_reqs();
    mst_ready = 1'b0;
    mst_rdata = '0;

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk_all_zero("reset");
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single write from requester 0, slave ready on the third BUSY cycle
    new_req(0, 1'b1, 16'h0008, 32'h12345678, 4'hF);
    run_txn(3, 32'h0);

    // Read from requester 1 returning 0xCAFEF00D
    new_req(1, 1'b0, 16'h0400, 32'h0, 4'h0);
    run_txn(1, 32'hCAFEF00D);

    // Requesters 0 and 1 reading back to back: grants alternate
    for (int t = 0; t < 4; t++) begin
      if (!pend[0]) new_req(0, 1'b0, 16'h0010, 32'h0, 4'h0);
      if (!pend[1]) new_req(1, 1'b0, 16'h0020, 32'h0, 4'h0);
      run_txn(1, 32'h1000 + 32'(t));
    end
    run_txn(2, 32'h5555AAAA);

    // Unmapped access times out, the next grant proceeds
    new_req(0, 1'b0, 16'h0100, 32'h0, 4'h0);
    new_req(1, 1'b1, 16'h0200, 32'hA5A5A5A5, 4'h3);
    run_txn(100, 32'h0);
    run_txn(2, 32'h0);
    // Ready on the expiry cycle wins over the timeout
    new_req(2, 1'b0, 16'h0300, 32'h0, 4'h0);
    run_txn(TIMEOUT, 32'h77665544);

    // Asynchronous reset in the middle of requester 1's access
    new_req(1, 1'b0, 16'h0444, 32'h0, 4'h0);
    drive_reqs();
    #1;
    @(posedge aclk); #1;
    new_req(0, 1'b1, 16'h0555, 32'h01020304, 4'hC);
    drive_reqs();
    mst_ready = 1'b1;
    mst_rdata = 32'h13572468;
    aresetn   = 1'b0;
    #1;
    chk_all_zero("areset");
    @(posedge aclk); #1;
    mst_ready = 1'b0;
    aresetn   = 1'b1;
    ptr       = 0;
    run_txn(1, 32'h0BADF00D);
    run_txn(1, 32'h0);

    // Synchronous reset for one cycle in the middle of requester 1's access
    new_req(1, 1'b0, 16'h0666, 32'h0, 4'h0);
    drive_reqs();
    #1;
    @(posedge aclk); #1;
    new_req(0, 1'b0, 16'h0777, 32'h0, 4'h0);
    drive_reqs();
    srst      = 1'b1;
    mst_ready = 1'b1;
    mst_rdata = 32'h24681357;
    #1;
    chk("srst_ready",  64'(req_ready), 64'd0);
    chk("srst_err",    64'(req_err),   64'd0);
    chk("srst_rdata",  64'(req_rdata), 64'd0);
    chk("srst_mst_en", 64'(mst_en),    64'd1);
    @(posedge aclk); #1;
    srst      = 1'b0;
    mst_ready = 1'b0;
    #1;
    chk_all_zero("post_srst");
    ptr = 0;
    run_txn(1, 32'h0);
    run_txn(2, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      any = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0))
          new_req(i, 1'($urandom), 16'($urandom), $urandom, 4'($urandom));
        if (pend[i]) any = 1;
      end
      if (any != 0) begin
        run_txn(int'($urandom_range(1, 20)), $urandom);
      end else begin
        drive_reqs();
        #1;
        chk("rand_idle_mst_en", 64'(mst_en), 64'd0);
        @(posedge aclk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
